// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - DMEM port bundle between the core and the data-memory responder
interface dmem_responder_if;
  logic        cs;
  logic        dm_w;
  logic        dm_r;
  logic [2:0]  select;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ram_out;

  modport master (
    output cs, dm_w, dm_r, select, addr, wdata,
    input  ram_out
  );

  modport slave (
    input  cs, dm_w, dm_r, select, addr, wdata,
    output ram_out
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - big-endian word RAM for the MIPS DMEM port with clear sweep and sticky faults
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_responder_if.slave        bus,
  output logic                   busy,
  output logic [2:0]             err,
  output logic [31:0]            err_addr
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [31:0]           SPAN     = 32'(4) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clr_idx;
  logic [31:0]             mem [DEPTH];

  logic [31:0]             off;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    in_range;
  logic                    ready;
  logic                    sel_ok;
  logic                    misaligned;
  logic [31:0]             word_q;
  logic [31:0]             new_word;
  logic [31:0]             lane_mask;
  logic [31:0]             lane_data;
  logic [4:0]              shamt;

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_widx;
  logic [31:0]             mem_wdata;
  logic [2:0]              fault;

  // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
  assign off      = bus.addr - BASE_ADDR;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign in_range = off < SPAN;
  assign ready    = !rst && (state_q == READY);
  assign word_q   = mem[idx];
  assign shamt    = {bus.addr[1:0], 3'b000};

  assign sel_ok   = (bus.select == 3'b001) || (bus.select == 3'b010) ||
                    (bus.select == 3'b100);

  always_comb begin
    misaligned = 1'b0;
    new_word   = word_q;
    lane_mask  = 32'hFF00_0000 >> shamt;
    lane_data  = {bus.wdata[7:0], 24'h0} >> shamt;
    case (bus.select)
      3'b100: begin
        misaligned = (bus.addr[1:0] != 2'b00);
        new_word   = bus.wdata;
      end
      3'b010: begin
        misaligned = bus.addr[0];
        new_word   = bus.addr[1] ? {word_q[31:16], bus.wdata[15:0]}
                                 : {bus.wdata[15:0], word_q[15:0]};
      end
      3'b001: new_word = (word_q & ~lane_mask) | lane_data;
      default: new_word = word_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy        = rst || (state_q == CLEAR);
    bus.ram_out = 32'h0;
    mem_we      = 1'b0;
    mem_widx    = clr_idx;
    mem_wdata   = 32'h0;
    fault       = 3'b000;

    case (state_q)
      CLEAR: begin
        if (!rst) begin
          mem_we = 1'b1;
          if (clr_idx == LAST_IDX) state_d = READY;
        end
      end
      READY: begin
        if (ready && bus.cs && (bus.dm_w || bus.dm_r)) begin
          if (bus.dm_r && in_range) bus.ram_out = word_q << shamt;
          // One access raises at most one fault: select, then range, then alignment.
          if (bus.dm_w && !sel_ok)          fault = 3'b100;
          else if (!in_range)               fault = 3'b010;
          else if (bus.dm_w && misaligned)  fault = 3'b001;
          else if (bus.dm_w) begin
            mem_we    = 1'b1;
            mem_widx  = idx;
            mem_wdata = new_word;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      clr_idx  <= '0;
      err      <= 3'b000;
      err_addr <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_idx <= clr_idx + 1'b1;
      if (fault != 3'b000) begin
        if (err == 3'b000) err_addr <= bus.addr;
        err <= err | fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [2:0]  err;
  logic [31:0] err_addr;
  int          total;
  int          bad;
  int          n;
  logic [31:0] rd;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_LOG2(11), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .err      (err),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cs = 1'b0; bus.dm_w = 1'b0; bus.dm_r = 1'b0;
    bus.select = 3'b100; bus.addr = BASE; bus.wdata = 32'h0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel,
                       input logic cs_v);
    bus.cs = cs_v; bus.dm_w = 1'b1; bus.dm_r = 1'b0;
    bus.select = sel; bus.addr = a; bus.wdata = d;
    step();
    idle();
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [31:0] q);
    bus.cs = 1'b1; bus.dm_w = 1'b0; bus.dm_r = 1'b1;
    bus.select = 3'b100; bus.addr = a;
    #2 q = bus.ram_out;
    step();
    idle();
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 5000) begin
      step();
      cnt++;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.cs = 1'b1; bus.dm_r = 1'b1; bus.addr = BASE + 32'd4;
    repeat (cycles) step();
    chk("busy_in_rst", {31'h0, busy}, 32'h1);
    chk("ram_out_in_rst", bus.ram_out, 32'h0);
    chk("err_in_rst", {29'h0, err}, 32'h0);
    idle();
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    idle();

    do_reset(2);
    count_busy(n);
    chk("sweep_len_0", n, 2048);

    do_wr(BASE, 32'hDEADBEEF, 3'b100, 1'b1);
    do_wr(BASE + 32'd400, 32'hA5A5A5A5, 3'b100, 1'b1);
    do_rd(BASE + 32'd400, rd);
    chk("garbage_loaded", rd, 32'hA5A5A5A5);

    do_reset(2);
    count_busy(n);
    chk("sweep_len_1", n, 2048);
    chk("busy_ready", {31'h0, busy}, 32'h0);
    do_rd(BASE, rd);
    chk("clr_word0", rd, 32'h0);
    do_rd(BASE + 32'd400, rd);
    chk("clr_word100", rd, 32'h0);

    do_wr(BASE + 32'd4, 32'h11223344, 3'b100, 1'b1);
    do_rd(BASE + 32'd4, rd); chk("rd_off0", rd, 32'h11223344);
    do_rd(BASE + 32'd5, rd); chk("rd_off1", rd, 32'h22334400);
    do_rd(BASE + 32'd6, rd); chk("rd_off2", rd, 32'h33440000);
    do_rd(BASE + 32'd7, rd); chk("rd_off3", rd, 32'h44000000);

    do_wr(BASE + 32'd6, 32'h000000AB, 3'b001, 1'b1);
    do_rd(BASE + 32'd4, rd); chk("sb_off2", rd, 32'h1122AB44);

    bus.cs = 1'b1; bus.dm_w = 1'b1; bus.dm_r = 1'b1;
    bus.select = 3'b010; bus.addr = BASE + 32'd4; bus.wdata = 32'h0000BEEF;
    #2 chk("rd_during_wr", bus.ram_out, 32'h1122AB44);
    step();
    idle();
    do_rd(BASE + 32'd4, rd); chk("sh_off0", rd, 32'hBEEFAB44);
    chk("err_clean", {29'h0, err}, 32'h0);

    do_wr(BASE + 32'd5, 32'h00001234, 3'b010, 1'b1);
    do_rd(BASE + 32'd4, rd); chk("mis_sh_word", rd, 32'hBEEFAB44);
    chk("mis_err", {29'h0, err}, 32'h1);
    chk("mis_err_addr", err_addr, BASE + 32'd5);
    do_wr(BASE + 32'd2, 32'hFFFFFFFF, 3'b100, 1'b1);
    chk("mis2_err", {29'h0, err}, 32'h1);
    chk("mis2_err_addr", err_addr, BASE + 32'd5);
    do_rd(BASE, rd); chk("mis2_word0", rd, 32'h0);

    do_wr(BASE + 32'h1FFC, 32'hCAFEF00D, 3'b100, 1'b1);
    do_rd(BASE + 32'h1FFC, rd); chk("last_word", rd, 32'hCAFEF00D);

    do_wr(BASE + 32'h2000, 32'h55555555, 3'b100, 1'b1);
    chk("oor_err", {29'h0, err}, 32'h3);
    chk("oor_err_addr", err_addr, BASE + 32'd5);
    do_rd(BASE, rd); chk("oor_word0", rd, 32'h0);

    do_wr(BASE + 32'd8, 32'h77777777, 3'b011, 1'b1);
    chk("sel_err", {29'h0, err}, 32'h7);
    do_rd(BASE + 32'd8, rd); chk("sel_word2", rd, 32'h0);

    do_wr(BASE + 32'd4, 32'h99999999, 3'b100, 1'b0);
    do_rd(BASE + 32'd4, rd); chk("cs0_word", rd, 32'hBEEFAB44);
    chk("cs0_err", {29'h0, err}, 32'h7);

    do_reset(1);
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_err_clr", {29'h0, err}, 32'h0);
    n = 0;
    while (busy && n < 5000) begin
      if (n == 5) begin
        bus.cs = 1'b1; bus.dm_w = 1'b1; bus.select = 3'b011;
        bus.addr = BASE - 32'd4; bus.wdata = 32'h12345678;
      end else begin
        idle();
      end
      step();
      n++;
    end
    idle();
    chk("sweep_len_mid", n, 2048);
    chk("busy_wr_err", {29'h0, err}, 32'h0);
    do_rd(BASE + 32'd4, rd); chk("mid_cleared", rd, 32'h0);

    do_rd(BASE - 32'd4, rd);
    chk("lw_below_data", rd, 32'h0);
    chk("lw_below_err", {29'h0, err}, 32'h2);
    chk("lw_below_addr", err_addr, BASE - 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
